// File: rtl/axi4_lite_reg_bank_if.sv
// axi4_lite_if: AXI4-Lite signal bundle with master and slave views
interface axi4_lite_if #(
  parameter int ADDR_BIT_WIDTH = 4,
  parameter int DATA_BIT_WIDTH = 32
);
  logic [ADDR_BIT_WIDTH-1:0]   awaddr;
  logic [2:0]                  awprot;
  logic                        awvalid, awready;
  logic [DATA_BIT_WIDTH-1:0]   wdata;
  logic [DATA_BIT_WIDTH/8-1:0] wstrb;
  logic                        wvalid, wready;
  logic [1:0]                  bresp;
  logic                        bvalid, bready;
  logic [ADDR_BIT_WIDTH-1:0]   araddr;
  logic [2:0]                  arprot;
  logic                        arvalid, arready;
  logic [DATA_BIT_WIDTH-1:0]   rdata;
  logic [1:0]                  rresp;
  logic                        rvalid, rready;
  modport slv_port (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport mst_port (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4_lite_reg_bank.sv
// axi4_lite_reg_bank: AXI4-Lite slave with two RW control regs, an RO status reg
// and a write-1-to-clear event reg.
module axi4_lite_reg_bank #(
  parameter int                        ADDR_BIT_WIDTH = 4,
  parameter int                        DATA_BIT_WIDTH = 32,
  parameter logic [DATA_BIT_WIDTH-1:0] REG0_RST_VAL   = '0,
  parameter logic [DATA_BIT_WIDTH-1:0] REG1_RST_VAL   = '0
) (
  input  logic                      i_clk,
  input  logic                      i_sync_rst,
  axi4_lite_if.slv_port             if_s_axi,
  output logic [DATA_BIT_WIDTH-1:0] o_reg0,
  output logic [DATA_BIT_WIDTH-1:0] o_reg1,
  input  logic [DATA_BIT_WIDTH-1:0] i_status,
  input  logic [DATA_BIT_WIDTH-1:0] i_evt,
  output logic                      o_evt_any
);
  localparam int         NB     = DATA_BIT_WIDTH / 8;
  localparam int         LSB    = $clog2(NB);
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  logic                      r_live, r_aw_held, r_w_held, r_bvalid, r_rvalid, r_evt_any;
  logic [1:0]                r_bresp, r_rresp;
  logic [ADDR_BIT_WIDTH-1:0] r_awaddr;
  logic [DATA_BIT_WIDTH-1:0] r_wdata, r_rdata, r_reg0, r_reg1, r_reg3;
  logic [NB-1:0]             r_wstrb;
  logic [31:0]               w_widx, w_ridx;
  logic [DATA_BIT_WIDTH-1:0] w_mask, w_clr, w_rdata;
  logic                      w_commit, w_aw_hs, w_w_hs, w_ar_hs, w_unused;
  for (genvar b = 0; b < NB; b++) begin : g_mask
    assign w_mask[b*8 +: 8] = {8{r_wstrb[b]}};
  end
  // r_live holds every ready low until the first cycle after reset releases
  assign if_s_axi.awready = r_live && !r_aw_held && !r_bvalid;
  assign if_s_axi.wready  = r_live && !r_w_held && !r_bvalid;
  assign if_s_axi.arready = r_live && !r_rvalid;
  assign if_s_axi.bvalid  = r_bvalid;
  assign if_s_axi.bresp   = r_bresp;
  assign if_s_axi.rvalid  = r_rvalid;
  assign if_s_axi.rresp   = r_rresp;
  assign if_s_axi.rdata   = r_rdata;
  assign w_aw_hs  = if_s_axi.awvalid && if_s_axi.awready;
  assign w_w_hs   = if_s_axi.wvalid && if_s_axi.wready;
  assign w_ar_hs  = if_s_axi.arvalid && if_s_axi.arready;
  assign w_commit = r_aw_held && r_w_held && !r_bvalid;
  assign w_widx   = 32'(r_awaddr[ADDR_BIT_WIDTH-1:LSB]);
  assign w_ridx   = 32'(if_s_axi.araddr[ADDR_BIT_WIDTH-1:LSB]);
  assign w_clr    = (w_commit && w_widx == 3) ? r_wdata & w_mask : '0;
  assign w_rdata  = w_ridx == 0 ? r_reg0 : w_ridx == 1 ? r_reg1 : w_ridx == 2 ? i_status :
                    w_ridx == 3 ? r_reg3 : '0;
  assign w_unused = ^{if_s_axi.awprot, if_s_axi.arprot, r_awaddr, if_s_axi.araddr};
  assign o_reg0    = r_reg0;
  assign o_reg1    = r_reg1;
  assign o_evt_any = r_evt_any;
  always_ff @(posedge i_clk) begin
    if (i_sync_rst) begin
      r_live    <= 1'b0;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_rvalid  <= 1'b0;
      r_bresp   <= OKAY;
      r_rresp   <= OKAY;
      r_rdata   <= '0;
      r_reg0    <= REG0_RST_VAL;
      r_reg1    <= REG1_RST_VAL;
      r_reg3    <= '0;
      r_evt_any <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_aw_hs) begin
        r_awaddr  <= if_s_axi.awaddr;
        r_aw_held <= 1'b1;
      end
      if (w_w_hs) begin
        r_wdata  <= if_s_axi.wdata;
        r_wstrb  <= if_s_axi.wstrb;
        r_w_held <= 1'b1;
      end
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= (w_widx == 0 || w_widx == 1 || w_widx == 3) ? OKAY : SLVERR;
        if (w_widx == 0) r_reg0 <= (r_reg0 & ~w_mask) | (r_wdata & w_mask);
        if (w_widx == 1) r_reg1 <= (r_reg1 & ~w_mask) | (r_wdata & w_mask);
      end else if (r_bvalid && if_s_axi.bready) r_bvalid <= 1'b0;
      if (w_ar_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rdata;
        r_rresp  <= w_ridx < 4 ? OKAY : SLVERR;
      end else if (r_rvalid && if_s_axi.rready) r_rvalid <= 1'b0;
      // an event set on the same bit wins over a W1C clear
      r_reg3    <= (r_reg3 & ~w_clr) | i_evt;
      r_evt_any <= |r_reg3;
    end
  end
endmodule

// File: tb/tb_axi4_lite_reg_bank.sv
// tb_axi4_lite_reg_bank: randomized self-checking bench for the AXI4-Lite register bank
module tb_axi4_lite_reg_bank;
  localparam int          AW   = 4;
  localparam int          DW   = 32;
  localparam logic [31:0] RST0 = 32'hCAFE_0000;
  localparam logic [31:0] RST1 = 32'h0;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] reg0, reg1, status, evt;
  logic        evt_any;
  int          checks = 0, errors = 0;
  logic [31:0] m_reg [4];
  always #5 clk = ~clk;
  axi4_lite_if #(.ADDR_BIT_WIDTH(AW), .DATA_BIT_WIDTH(DW)) axi ();
  axi4_lite_reg_bank #(.ADDR_BIT_WIDTH(AW), .DATA_BIT_WIDTH(DW), .REG0_RST_VAL(RST0), .REG1_RST_VAL(RST1)) dut (
    .i_clk(clk), .i_sync_rst(rst), .if_s_axi(axi), .o_reg0(reg0), .o_reg1(reg1),
    .i_status(status), .i_evt(evt), .o_evt_any(evt_any)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [1:0] model_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx = int'(a) / 4;
    if (idx == 0) m_reg[0] = merge(m_reg[0], d, s);
    if (idx == 1) m_reg[1] = merge(m_reg[1], d, s);
    if (idx == 3) m_reg[3] = m_reg[3] & ~merge(32'h0, d, s);
    return idx == 2 ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [31:0] model_read(input logic [3:0] a);
    int idx = int'(a) / 4;
    return idx == 2 ? status : m_reg[idx];
  endfunction

  task automatic model_reset();
    m_reg[0] = RST0; m_reg[1] = RST1; m_reg[2] = 0; m_reg[3] = 0;
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] resp);
    int n = 0;
    logic aw_go, w_go;
    @(posedge clk); #1;
    axi.awaddr = a; axi.awvalid = 1; axi.wdata = d; axi.wstrb = s; axi.wvalid = 1; axi.bready = 1;
    while ((axi.awvalid || axi.wvalid) && n < 20) begin
      @(negedge clk); aw_go = axi.awready; w_go = axi.wready;
      @(posedge clk); #1;
      if (aw_go) axi.awvalid = 0;
      if (w_go) axi.wvalid = 0;
      n++;
    end
    axi.awvalid = 0; axi.wvalid = 0; n = 0;
    @(negedge clk);
    while (!axi.bvalid && n < 20) begin @(negedge clk); n++; end
    resp = axi.bresp;
    checks++;
    if (axi.bvalid !== 1'b1) begin errors++; $display("FAIL write_timeout addr=%h got bvalid=%b exp=1", a, axi.bvalid); end
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] r);
    int n = 0;
    logic go;
    @(posedge clk); #1;
    axi.araddr = a; axi.arvalid = 1; axi.rready = 1;
    do begin
      @(negedge clk); go = axi.arready;
      @(posedge clk); #1; n++;
    end while (!go && n < 20);
    axi.arvalid = 0;
    @(negedge clk);
    d = axi.rdata; r = axi.rresp;
    checks++;
    if (axi.rvalid !== 1'b1) begin errors++; $display("FAIL read_latency addr=%h got rvalid=%b exp=1", a, axi.rvalid); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1; evt = 0; status = 0;
    axi.awvalid = 0; axi.wvalid = 0; axi.arvalid = 0; axi.bready = 1; axi.rready = 1;
    axi.awaddr = 0; axi.araddr = 0; axi.wdata = 0; axi.wstrb = 0; axi.awprot = 0; axi.arprot = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid} !== 5'b0) begin
      errors++; $display("FAIL reset_handshake got=%b exp=00000", {axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid});
    end
    checks++;
    if ({axi.bresp, axi.rresp, axi.rdata} !== 36'h0) begin errors++; $display("FAIL reset_resp got=%h exp=0", {axi.bresp, axi.rresp, axi.rdata}); end
    checks++;
    if ({reg0, reg1, evt_any} !== {RST0, RST1, 1'b0}) begin errors++; $display("FAIL reset_regs got=%h %h %b exp=%h %h 0", reg0, reg1, evt_any, RST0, RST1); end
    @(posedge clk); #1 rst = 0;
    @(posedge clk); @(negedge clk);
    checks++;
    if ({axi.awready, axi.wready, axi.arready} !== 3'b111) begin errors++; $display("FAIL ready_after_reset got=%b exp=111", {axi.awready, axi.wready, axi.arready}); end
  endtask

  task automatic test_same_cycle_write();
    logic [1:0] exp = model_write(4'h0, 32'hDEADBEEF, 4'hF);
    @(posedge clk); #1;
    axi.awaddr = 4'h0; axi.wdata = 32'hDEADBEEF; axi.wstrb = 4'hF; axi.awvalid = 1; axi.wvalid = 1; axi.bready = 1;
    @(posedge clk); #1 axi.awvalid = 0; axi.wvalid = 0;
    @(negedge clk);
    checks++;
    if (axi.bvalid !== 1'b0) begin errors++; $display("FAIL same_early_bvalid got=%b exp=0", axi.bvalid); end
    @(negedge clk);
    checks++;
    if ({axi.bvalid, axi.bresp} !== {1'b1, exp}) begin errors++; $display("FAIL same_bresp got=%b%b exp=1%b", axi.bvalid, axi.bresp, exp); end
    checks++;
    if (reg0 !== m_reg[0]) begin errors++; $display("FAIL same_reg0 got=%h exp=%h", reg0, m_reg[0]); end
    @(negedge clk);
    checks++;
    if ({axi.bvalid, axi.awready, axi.wready} !== 3'b011) begin errors++; $display("FAIL same_reopen got=%b exp=011", {axi.bvalid, axi.awready, axi.wready}); end
  endtask

  task automatic test_w_before_aw();
    logic [1:0] exp = model_write(4'h4, 32'h11223344, 4'h5);
    @(posedge clk); #1;
    axi.wdata = 32'h11223344; axi.wstrb = 4'h5; axi.wvalid = 1;
    @(posedge clk); #1 axi.wvalid = 0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({axi.wready, axi.awready, axi.bvalid} !== 3'b010) begin errors++; $display("FAIL w_first_hold got=%b exp=010", {axi.wready, axi.awready, axi.bvalid}); end
      @(posedge clk); #1;
    end
    axi.awaddr = 4'h4; axi.awvalid = 1;
    @(posedge clk); #1 axi.awvalid = 0;
    @(negedge clk);
    checks++;
    if ({axi.wready, axi.awready, axi.bvalid} !== 3'b000) begin errors++; $display("FAIL w_first_commit_cycle got=%b exp=000", {axi.wready, axi.awready, axi.bvalid}); end
    @(negedge clk);
    checks++;
    if ({axi.bvalid, axi.bresp, reg1} !== {1'b1, exp, 32'h00220044} || m_reg[1] !== 32'h00220044) begin
      errors++; $display("FAIL w_first_reg1 got=%b %b %h exp=1 %b %h", axi.bvalid, axi.bresp, reg1, exp, m_reg[1]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_status_read();
    logic [1:0] resp;
    logic [1:0] exp;
    status = 32'hA5A5_0001;
    @(posedge clk); #1 axi.araddr = 4'h8; axi.arvalid = 1; axi.rready = 1;
    @(posedge clk); #1 axi.arvalid = 0; status = 32'h0BAD_0BAD;
    @(negedge clk);
    checks++;
    if ({axi.rvalid, axi.rresp, axi.rdata} !== {1'b1, 2'b00, 32'hA5A50001}) begin
      errors++; $display("FAIL status_read got=%b %b %h exp=1 00 a5a50001", axi.rvalid, axi.rresp, axi.rdata);
    end
    @(posedge clk); #1;
    exp = model_write(4'h8, 32'hFFFF_FFFF, 4'hF);
    axi_write(4'h8, 32'hFFFF_FFFF, 4'hF, resp);
    checks++;
    if (resp !== exp) begin errors++; $display("FAIL ro_bresp got=%b exp=%b", resp, exp); end
    checks++;
    if ({reg0, reg1} !== {m_reg[0], m_reg[1]}) begin errors++; $display("FAIL ro_no_change got=%h %h exp=%h %h", reg0, reg1, m_reg[0], m_reg[1]); end
  endtask

  task automatic test_events();
    logic [31:0] d;
    logic [1:0] r;
    @(posedge clk); #1 evt = 32'h3;
    @(posedge clk); #1 evt = 0;
    m_reg[3] = m_reg[3] | 32'h3;
    @(negedge clk);
    checks++;
    if (evt_any !== 1'b0) begin errors++; $display("FAIL evt_any_registered got=%b exp=0", evt_any); end
    @(negedge clk);
    checks++;
    if (evt_any !== 1'b1) begin errors++; $display("FAIL evt_any_set got=%b exp=1", evt_any); end
    axi_read(4'hC, d, r);
    checks++;
    if ({d, r} !== {m_reg[3], 2'b00}) begin errors++; $display("FAIL evt_read got=%h %b exp=%h 00", d, r, m_reg[3]); end
    @(posedge clk); #1;
    axi.awaddr = 4'hC; axi.wdata = 32'h1; axi.wstrb = 4'hF; axi.awvalid = 1; axi.wvalid = 1; axi.bready = 1;
    @(posedge clk); #1 axi.awvalid = 0; axi.wvalid = 0; evt = 32'h1;
    @(posedge clk); #1 evt = 0;
    m_reg[3] = (m_reg[3] & ~32'h1) | 32'h1;
    @(posedge clk); #1;
    axi_read(4'hC, d, r);
    checks++;
    if (d !== m_reg[3] || d !== 32'h3) begin errors++; $display("FAIL evt_set_wins got=%h exp=%h", d, m_reg[3]); end
    void'(model_write(4'hC, 32'h1, 4'hF));
    axi_write(4'hC, 32'h1, 4'hF, r);
    axi_read(4'hC, d, r);
    checks++;
    if (d !== m_reg[3] || d !== 32'h2) begin errors++; $display("FAIL evt_w1c got=%h exp=%h", d, m_reg[3]); end
    void'(model_write(4'hC, 32'h2, 4'h1));
    axi_write(4'hC, 32'h2, 4'h1, r);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (evt_any !== 1'b0) begin errors++; $display("FAIL evt_any_clear got=%b exp=0", evt_any); end
  endtask

  task automatic test_stall();
    logic [31:0] d = $urandom | 32'h1;
    logic [1:0] exp = model_write(4'h0, d, 4'hF);
    int n = 0;
    @(posedge clk); #1;
    axi.awaddr = 4'h0; axi.wdata = d; axi.wstrb = 4'hF; axi.awvalid = 1; axi.wvalid = 1; axi.bready = 0;
    @(posedge clk); #1 axi.awvalid = 0; axi.wvalid = 0;
    @(negedge clk);
    while (!axi.bvalid && n < 10) begin @(negedge clk); n++; end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({axi.awready, axi.wready, axi.bvalid, axi.bresp} !== {3'b001, exp}) begin
        errors++; $display("FAIL b_stall cyc=%0d got=%b exp=001%b", i, {axi.awready, axi.wready, axi.bvalid, axi.bresp}, exp);
      end
      @(negedge clk);
    end
    #1 axi.bready = 1;
    @(negedge clk);
    checks++;
    if (axi.bvalid !== 1'b0) begin errors++; $display("FAIL b_release got=%b exp=0", axi.bvalid); end
    @(posedge clk); #1 axi.araddr = 4'h0; axi.arvalid = 1; axi.rready = 0;
    @(posedge clk); #1 axi.arvalid = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({axi.rvalid, axi.arready, axi.rresp, axi.rdata} !== {2'b10, 2'b00, m_reg[0]}) begin
        errors++; $display("FAIL r_stall cyc=%0d got=%b%b %b %h exp=10 00 %h", i, axi.rvalid, axi.arready, axi.rresp, axi.rdata, m_reg[0]);
      end
    end
    #1 axi.rready = 1;
    @(negedge clk);
    checks++;
    if (axi.rvalid !== 1'b0) begin errors++; $display("FAIL r_release got=%b exp=0", axi.rvalid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] old = m_reg[1];
    logic [31:0] d = $urandom;
    int hs = 0;
    @(posedge clk); #1;
    axi.awaddr = 4'h4; axi.wdata = d; axi.wstrb = 4'hF; axi.awvalid = 1; axi.wvalid = 1; axi.bready = 1; axi.rready = 1;
    @(posedge clk); #1 axi.awvalid = 0; axi.wvalid = 0; axi.araddr = 4'h4; axi.arvalid = 1;
    @(posedge clk); #1 axi.arvalid = 0;
    void'(model_write(4'h4, d, 4'hF));
    @(negedge clk);
    checks++;
    if ({axi.rvalid, axi.rdata} !== {1'b1, old}) begin errors++; $display("FAIL read_vs_commit got=%b %h exp=1 %h", axi.rvalid, axi.rdata, old); end
    checks++;
    if ({axi.bvalid, reg1} !== {1'b1, m_reg[1]}) begin errors++; $display("FAIL commit_vs_read got=%b %h exp=1 %h", axi.bvalid, reg1, m_reg[1]); end
    @(posedge clk); #1 axi.araddr = 4'h0; axi.arvalid = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (axi.arvalid && axi.arready) hs++;
    end
    #1 axi.arvalid = 0;
    checks++;
    if (hs !== 5) begin errors++; $display("FAIL read_throughput got=%0d exp=5", hs); end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_random();
    logic [3:0]  a, s;
    logic [31:0] d;
    logic [1:0]  r, exp;
    for (int i = 0; i < 40; i++) begin
      a = 4'($urandom); d = $urandom; s = 4'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        exp = model_write(a, d, s);
        axi_write(a, d, s, r);
        checks++;
        if (r !== exp) begin errors++; $display("FAIL rand_bresp i=%0d addr=%h got=%b exp=%b", i, a, r, exp); end
        checks++;
        if ({reg0, reg1} !== {m_reg[0], m_reg[1]}) begin errors++; $display("FAIL rand_regs i=%0d got=%h %h exp=%h %h", i, reg0, reg1, m_reg[0], m_reg[1]); end
      end else begin
        status = $urandom;
        axi_read(a, d, r);
        checks++;
        if ({d, r} !== {model_read(a), 2'b00}) begin errors++; $display("FAIL rand_read i=%0d addr=%h got=%h %b exp=%h 00", i, a, d, r, model_read(a)); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int bseen = 0;
    @(posedge clk); #1;
    axi.awaddr = 4'h0; axi.awvalid = 1; axi.araddr = 4'h4; axi.arvalid = 1; axi.rready = 0; axi.bready = 1;
    @(posedge clk); #1 axi.awvalid = 0; axi.arvalid = 0;
    @(negedge clk);
    checks++;
    if ({axi.rvalid, axi.awready} !== 2'b10) begin errors++; $display("FAIL mid_setup got=%b exp=10", {axi.rvalid, axi.awready}); end
    #1 rst = 1;
    @(negedge clk);
    model_reset();
    checks++;
    if ({axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid} !== 5'b0) begin
      errors++; $display("FAIL mid_reset_flags got=%b exp=00000", {axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid});
    end
    checks++;
    if ({reg0, reg1} !== {m_reg[0], m_reg[1]}) begin errors++; $display("FAIL mid_reset_regs got=%h %h exp=%h %h", reg0, reg1, m_reg[0], m_reg[1]); end
    #1 rst = 0; axi.rready = 1;
    @(posedge clk); #1 axi.wdata = 32'h5555_5555; axi.wstrb = 4'hF; axi.wvalid = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (axi.bvalid) bseen++;
      @(posedge clk); #1 if (!axi.wready) axi.wvalid = 0;
    end
    axi.wvalid = 0;
    checks++;
    if (bseen !== 0) begin errors++; $display("FAIL mid_no_bvalid got=%0d exp=0", bseen); end
    checks++;
    if (reg0 !== m_reg[0]) begin errors++; $display("FAIL mid_reg0_kept got=%h exp=%h", reg0, m_reg[0]); end
  endtask

  initial begin
    test_reset();
    test_same_cycle_write();
    test_w_before_aw();
    test_status_read();
    test_events();
    test_stall();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
